test_pattern_gen: RTL and testbench
===================================

Name: test_pattern_gen

Overview:
Parametrised video test-pattern source combining a pixel-clock prescaler, an h/v timing generator and a 4-mode pattern engine. It drives a VGA-style connector directly, or feeds downstream pixel logic with aligned hpos/vpos/display_on. It replaces the fixed-timing, single-pattern generator with configurable timing, channel depth, sync polarity and run-time pattern selection.

Parameters:
CLK_DIV, 4, system clocks per pixel (>=1); 1 means pix_ce is constantly high.
H_DISPLAY, 640, visible pixels per line; must be divisible by 8.
H_FRONT, 16, horizontal front porch in pixels.
H_SYNC, 96, hsync pulse width in pixels.
H_BACK, 48, horizontal back porch in pixels.
V_DISPLAY, 480, visible lines.
V_FRONT, 10, vertical front porch in lines.
V_SYNC, 2, vsync pulse width in lines.
V_BACK, 33, vertical back porch in lines.
SYNC_NEG, 1, 1 = syncs active-low, 0 = active-high.
CHAN_BITS, 4, bits per colour channel; must be >=1 and <=8.
POS_W, 10, width of hpos/vpos; must hold H_TOTAL-1 and V_TOTAL-1.

Ports:
clk  input  1  system clock; all state on rising edge.
reset  input  1  asynchronous, active-high reset.
mode  input  2  pattern select: 0 grid, 1 colour bars, 2 checkerboard, 3 gradient.
pix_ce  output  1  pixel enable; high one clk in every CLK_DIV clks.
hsync  output  1  horizontal sync, polarity per SYNC_NEG.
vsync  output  1  vertical sync, polarity per SYNC_NEG.
display_on  output  1  high while the output pixel is in the visible area.
hpos  output  POS_W  horizontal position of the current output pixel.
vpos  output  POS_W  vertical position of the current output pixel.
frame_start  output  1  one-clk pulse when pixel (0,0) is presented.
rgb  output  3*CHAN_BITS  {b,g,r} with r in the LSBs.

Behaviour:
- Totals: H_TOTAL = H_DISPLAY+H_FRONT+H_SYNC+H_BACK; V_TOTAL likewise.
- Prescaler `div` counts 0..CLK_DIV-1 and wraps. pix_ce = (div == CLK_DIV-1), combinational from `div`.
- Internal counters h_cnt and v_cnt advance only on pix_ce.
  - h_cnt wraps from H_TOTAL-1 to 0.
  - v_cnt increments when h_cnt wraps, and wraps from V_TOTAL-1 to 0.
- Output registers load only on pix_ce, from the pre-increment h_cnt/v_cnt:
  - hpos = h_cnt, vpos = v_cnt.
  - display_on = (h_cnt < H_DISPLAY) && (v_cnt < V_DISPLAY).
  - hsync active iff H_DISPLAY+H_FRONT <= h_cnt < H_DISPLAY+H_FRONT+H_SYNC.
  - vsync active iff V_DISPLAY+V_FRONT <= v_cnt < V_DISPLAY+V_FRONT+V_SYNC.
  - rgb = pattern(h_cnt, v_cnt, mode_q).
  - All outputs are mutually aligned and hold between pix_ce pulses; latency from counter to outputs is one pixel.
- mode_q samples `mode` on the pix_ce where h_cnt==0 && v_cnt==0, so changes take effect only at frame boundaries and never tear mid-frame.
- frame_start is registered: high exactly one clk, coincident with the output registers presenting (0,0).
- Blanking: rgb = 0 whenever display_on would be 0.
- Patterns (a 1-bit value is replicated CHAN_BITS times; "full" = all ones):
  - mode 0, grid: r = (h[2:0]==0)||(v[2:0]==0); g = v[4]; b = h[4].
  - mode 1, colour bars: bar index i (0..7) advances every H_DISPLAY/8 pixels. Derive i from a bar sub-counter cleared at h_cnt==0; no divider. r = ~i[1], g = ~i[2], b = ~i[0]. Order: white, yellow, cyan, green, magenta, red, blue, black.
  - mode 2, checkerboard: full white when h[5]^v[5], else black.
  - mode 3, gradient: r = h[CHAN_BITS+1:2]; g = v[CHAN_BITS+1:2]; b = (h+v)[CHAN_BITS+2:3], with the sum truncated to POS_W.
- Reset, asynchronous, any time including mid-line:
  - div, h_cnt, v_cnt, bar counter, mode_q = 0.
  - hpos = vpos = 0, display_on = 0, rgb = 0, frame_start = 0.
  - hsync and vsync at their inactive level (SYNC_NEG ? 1 : 0).
  - After release, the first pix_ce presents (0,0) and pulses frame_start.

Test Plan:
- Defaults, mode 0, run 2 frames -> each hsync active 96 pixels (384 clks) every 800 pixels. vsync active lines 490–491. frame_start period 800*525*4 = 1,680,000 clks.
- Mode 1 -> rgb at hpos 0 = 0xFFF, hpos 80 = 0x0FF (yellow), hpos 560 = 0x000, hpos 639 = 0x000. At hpos 640..799, rgb = 0 with display_on = 0.
- Change mode 0->2 at vpos 100 -> frame continues as grid; from the next (0,0), pixel (32,0) = 0xFFF and (0,0) = 0x000.
- Assert reset at hpos 300/vpos 200 for 3 clks -> outputs at reset values immediately (hsync = vsync = 1). First pix_ce after release gives hpos = vpos = 0 and frame_start = 1.
- CLK_DIV=1, SYNC_NEG=0, CHAN_BITS=8 -> pix_ce constantly 1; syncs idle 0 and pulse high. Grid pixel (8,8) r = 0xFF, and rgb is 24 bits wide.
- Mode 3 at (20,12) -> r = 0x5, g = 0x3, b = 0x4.

Source files
------------

// File: rtl/test_pattern_gen.sv
// Video test-pattern source: pixel prescaler, h/v timing counters and a 4-mode pattern engine.
// Latency: every output is registered one pixel after the counter value it describes.
// Backpressure: none; free-running source, downstream logic qualifies on pix_ce.
module test_pattern_gen #(
    parameter int CLK_DIV   = 4,
    parameter int H_DISPLAY = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter int SYNC_NEG  = 1,
    parameter int CHAN_BITS = 4,
    parameter int POS_W     = 10
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [1:0]             mode,
    output logic                   pix_ce,
    output logic                   hsync,
    output logic                   vsync,
    output logic                   display_on,
    output logic [POS_W-1:0]       hpos,
    output logic [POS_W-1:0]       vpos,
    output logic                   frame_start,
    output logic [3*CHAN_BITS-1:0] rgb
);
    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BAR_W   = H_DISPLAY / 8;
    localparam int BAR_CW  = (BAR_W > 1) ? $clog2(BAR_W) : 1;

    localparam logic [DIV_W-1:0]  DIV_LAST   = DIV_W'(CLK_DIV - 1);
    localparam logic [POS_W-1:0]  H_LAST     = POS_W'(H_TOTAL - 1);
    localparam logic [POS_W-1:0]  V_LAST     = POS_W'(V_TOTAL - 1);
    localparam logic [POS_W-1:0]  H_VIS_LAST = POS_W'(H_DISPLAY - 1);
    localparam logic [POS_W-1:0]  V_VIS_LAST = POS_W'(V_DISPLAY - 1);
    localparam logic [POS_W-1:0]  HS_FIRST   = POS_W'(H_DISPLAY + H_FRONT);
    localparam logic [POS_W-1:0]  HS_LAST    = POS_W'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [POS_W-1:0]  VS_FIRST   = POS_W'(V_DISPLAY + V_FRONT);
    localparam logic [POS_W-1:0]  VS_LAST    = POS_W'(V_DISPLAY + V_FRONT + V_SYNC - 1);
    localparam logic [BAR_CW-1:0] BAR_LAST   = BAR_CW'(BAR_W - 1);
    localparam logic              SYNC_IDLE  = (SYNC_NEG != 0);

    logic [DIV_W-1:0]       div_q, div_d;
    logic [POS_W-1:0]       h_cnt_q, h_cnt_d;
    logic [POS_W-1:0]       v_cnt_q, v_cnt_d;
    logic [BAR_CW-1:0]      bar_sub_q, bar_sub_d;
    logic [2:0]             bar_idx_q, bar_idx_d;
    logic [1:0]             mode_q, mode_d;
    logic [POS_W-1:0]       hpos_q, hpos_d;
    logic [POS_W-1:0]       vpos_q, vpos_d;
    logic                   display_on_q, display_on_d;
    logic                   hsync_q, hsync_d;
    logic                   vsync_q, vsync_d;
    logic                   frame_start_q, frame_start_d;
    logic [3*CHAN_BITS-1:0] rgb_q, rgb_d;

    logic                   h_wrap, v_wrap, at_origin, visible;
    logic [1:0]             mode_sel;
    logic [POS_W-1:0]       pos_sum;
    logic [CHAN_BITS-1:0]   r_pix, g_pix, b_pix;

    assign pix_ce    = (div_q == DIV_LAST);
    assign h_wrap    = (h_cnt_q == H_LAST);
    assign v_wrap    = (v_cnt_q == V_LAST);
    assign at_origin = (h_cnt_q == '0) && (v_cnt_q == '0);
    assign visible   = (h_cnt_q <= H_VIS_LAST) && (v_cnt_q <= V_VIS_LAST);
    assign pos_sum   = h_cnt_q + v_cnt_q;
    // The origin pixel already belongs to the new frame, so it uses the freshly sampled mode.
    assign mode_sel  = at_origin ? mode : mode_q;

    always_comb begin
        div_d     = div_q;
        h_cnt_d   = h_cnt_q;
        v_cnt_d   = v_cnt_q;
        bar_sub_d = bar_sub_q;
        bar_idx_d = bar_idx_q;
        mode_d    = mode_q;
        if (pix_ce) begin
            div_d   = '0;
            h_cnt_d = h_wrap ? '0 : h_cnt_q + POS_W'(1);
            if (h_wrap) begin
                v_cnt_d = v_wrap ? '0 : v_cnt_q + POS_W'(1);
            end
            // Bar state always describes the current h_cnt: index = h_cnt / BAR_W without a divider.
            if (h_wrap) begin
                bar_sub_d = '0;
                bar_idx_d = '0;
            end else if (bar_sub_q == BAR_LAST) begin
                bar_sub_d = '0;
                bar_idx_d = bar_idx_q + 3'd1;
            end else begin
                bar_sub_d = bar_sub_q + BAR_CW'(1);
            end
            if (at_origin) begin
                mode_d = mode;
            end
        end else begin
            div_d = div_q + DIV_W'(1);
        end
    end

    always_comb begin
        r_pix = '0;
        g_pix = '0;
        b_pix = '0;
        case (mode_sel)
            2'd0: begin
                r_pix = {CHAN_BITS{(h_cnt_q[2:0] == 3'd0) || (v_cnt_q[2:0] == 3'd0)}};
                g_pix = {CHAN_BITS{v_cnt_q[4]}};
                b_pix = {CHAN_BITS{h_cnt_q[4]}};
            end
            2'd1: begin
                r_pix = {CHAN_BITS{~bar_idx_q[1]}};
                g_pix = {CHAN_BITS{~bar_idx_q[2]}};
                b_pix = {CHAN_BITS{~bar_idx_q[0]}};
            end
            2'd2: begin
                r_pix = {CHAN_BITS{h_cnt_q[5] ^ v_cnt_q[5]}};
                g_pix = r_pix;
                b_pix = r_pix;
            end
            default: begin
                r_pix = CHAN_BITS'(h_cnt_q >> 2);
                g_pix = CHAN_BITS'(v_cnt_q >> 2);
                b_pix = CHAN_BITS'(pos_sum >> 3);
            end
        endcase
    end

    always_comb begin
        hpos_d        = hpos_q;
        vpos_d        = vpos_q;
        display_on_d  = display_on_q;
        hsync_d       = hsync_q;
        vsync_d       = vsync_q;
        rgb_d         = rgb_q;
        frame_start_d = 1'b0;
        if (pix_ce) begin
            hpos_d        = h_cnt_q;
            vpos_d        = v_cnt_q;
            display_on_d  = visible;
            hsync_d       = ((h_cnt_q >= HS_FIRST) && (h_cnt_q <= HS_LAST)) ^ SYNC_IDLE;
            vsync_d       = ((v_cnt_q >= VS_FIRST) && (v_cnt_q <= VS_LAST)) ^ SYNC_IDLE;
            rgb_d         = visible ? {b_pix, g_pix, r_pix} : '0;
            frame_start_d = at_origin;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q         <= '0;
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            bar_sub_q     <= '0;
            bar_idx_q     <= '0;
            mode_q        <= '0;
            hpos_q        <= '0;
            vpos_q        <= '0;
            display_on_q  <= 1'b0;
            hsync_q       <= SYNC_IDLE;
            vsync_q       <= SYNC_IDLE;
            frame_start_q <= 1'b0;
            rgb_q         <= '0;
        end else begin
            div_q         <= div_d;
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            bar_sub_q     <= bar_sub_d;
            bar_idx_q     <= bar_idx_d;
            mode_q        <= mode_d;
            hpos_q        <= hpos_d;
            vpos_q        <= vpos_d;
            display_on_q  <= display_on_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            frame_start_q <= frame_start_d;
            rgb_q         <= rgb_d;
        end
    end

    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign display_on  = display_on_q;
    assign hpos        = hpos_q;
    assign vpos        = vpos_q;
    assign frame_start = frame_start_q;
    assign rgb         = rgb_q;

endmodule

// File: tb/tb_test_pattern_gen.sv
// Bench for test_pattern_gen: two reduced-timing instances (divided clock with active-low syncs,
// and CLK_DIV=1 with active-high syncs and 8-bit channels) checked every clock against a pixel-index model.
module tb_test_pattern_gen;
    localparam int A_D = 3, A_HD = 64, A_HF = 2, A_HS = 6, A_HB = 4;
    localparam int A_VD = 36, A_VF = 2, A_VS = 2, A_VB = 2, A_CB = 4, A_PW = 10;
    localparam int A_FRAME = (A_HD + A_HF + A_HS + A_HB) * (A_VD + A_VF + A_VS + A_VB) * A_D;
    localparam int B_D = 1, B_HD = 32, B_HF = 2, B_HS = 4, B_HB = 2;
    localparam int B_VD = 16, B_VF = 1, B_VS = 2, B_VB = 1, B_CB = 8, B_PW = 10;

    typedef struct {
        bit ce, hs, vs, de, fs;
        int h, v, rgb;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    logic [1:0] mode_a, mode_b;
    logic pix_ce_a, hsync_a, vsync_a, de_a, fs_a;
    logic [A_PW-1:0] hpos_a, vpos_a;
    logic [3*A_CB-1:0] rgb_a;
    logic pix_ce_b, hsync_b, vsync_b, de_b, fs_b;
    logic [B_PW-1:0] hpos_b, vpos_b;
    logic [3*B_CB-1:0] rgb_b;

    int n_checks = 0;
    int n_errors = 0;
    int n_a = 0, fm_a = 0, n_b = 0, fm_b = 0;
    exp_t ea, eb;

    always #5 clk = ~clk;

    test_pattern_gen #(
        .CLK_DIV(A_D), .H_DISPLAY(A_HD), .H_FRONT(A_HF), .H_SYNC(A_HS), .H_BACK(A_HB),
        .V_DISPLAY(A_VD), .V_FRONT(A_VF), .V_SYNC(A_VS), .V_BACK(A_VB),
        .SYNC_NEG(1), .CHAN_BITS(A_CB), .POS_W(A_PW)
    ) dut_a (
        .clk(clk), .reset(reset), .mode(mode_a), .pix_ce(pix_ce_a), .hsync(hsync_a),
        .vsync(vsync_a), .display_on(de_a), .hpos(hpos_a), .vpos(vpos_a),
        .frame_start(fs_a), .rgb(rgb_a)
    );

    test_pattern_gen #(
        .CLK_DIV(B_D), .H_DISPLAY(B_HD), .H_FRONT(B_HF), .H_SYNC(B_HS), .H_BACK(B_HB),
        .V_DISPLAY(B_VD), .V_FRONT(B_VF), .V_SYNC(B_VS), .V_BACK(B_VB),
        .SYNC_NEG(0), .CHAN_BITS(B_CB), .POS_W(B_PW)
    ) dut_b (
        .clk(clk), .reset(reset), .mode(mode_b), .pix_ce(pix_ce_b), .hsync(hsync_b),
        .vsync(vsync_b), .display_on(de_b), .hpos(hpos_b), .vpos(vpos_b),
        .frame_start(fs_b), .rgb(rgb_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            if (n_errors <= 20)
                $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int pattern(input int h, input int v, input int m,
                                   input int hd, input int cb, input int pw);
        int full, r, g, b, i;
        full = (1 << cb) - 1;
        case (m)
            0: begin
                r = ((h % 8 == 0) || (v % 8 == 0)) ? full : 0;
                g = ((v >> 4) & 1) != 0 ? full : 0;
                b = ((h >> 4) & 1) != 0 ? full : 0;
            end
            1: begin
                i = h / (hd / 8);
                r = ((i >> 1) & 1) != 0 ? 0 : full;
                g = ((i >> 2) & 1) != 0 ? 0 : full;
                b = (i & 1) != 0 ? 0 : full;
            end
            2: begin
                r = (((h >> 5) ^ (v >> 5)) & 1) != 0 ? full : 0;
                g = r;
                b = r;
            end
            default: begin
                r = (h >> 2) & full;
                g = (v >> 2) & full;
                b = (((h + v) % (1 << pw)) >> 3) & full;
            end
        endcase
        return (b << (2 * cb)) | (g << cb) | r;
    endfunction

    // n = clock edges since reset release; the pixel shown after edge n is index n/d-1 in raster order.
    function automatic exp_t model(input int d, input int hd, input int hf, input int hs, input int hb,
                                   input int vd, input int vf, input int vs, input int vb,
                                   input int sneg, input int cb, input int pw,
                                   input int n, input int fm, input int mnow);
        exp_t e;
        int ht, vt, k, m;
        ht = hd + hf + hs + hb;
        vt = vd + vf + vs + vb;
        e.ce = ((n % d) == d - 1);
        e.hs = (sneg != 0);
        e.vs = (sneg != 0);
        e.de = 1'b0;
        e.fs = 1'b0;
        e.h = 0;
        e.v = 0;
        e.rgb = 0;
        if (n >= d) begin
            k = n / d - 1;
            e.h = k % ht;
            e.v = (k / ht) % vt;
            e.fs = ((n % d) == 0) && ((k % (ht * vt)) == 0);
            m = e.fs ? mnow : fm;
            e.de = (e.h < hd) && (e.v < vd);
            e.hs = ((e.h >= hd + hf) && (e.h < hd + hf + hs)) ? (sneg == 0) : (sneg != 0);
            e.vs = ((e.v >= vd + vf) && (e.v < vd + vf + vs)) ? (sneg == 0) : (sneg != 0);
            if (e.de) e.rgb = pattern(e.h, e.v, m, hd, cb, pw);
        end
        return e;
    endfunction

    always @(posedge clk) begin
        #1;
        if (reset) begin
            n_a = 0;
        end else begin
            n_a++;
            ea = model(A_D, A_HD, A_HF, A_HS, A_HB, A_VD, A_VF, A_VS, A_VB, 1, A_CB, A_PW,
                       n_a, fm_a, 32'(mode_a));
            if (ea.fs) fm_a = 32'(mode_a);
            chk("A pix_ce", 32'(pix_ce_a), 32'(ea.ce));
            chk("A hsync", 32'(hsync_a), 32'(ea.hs));
            chk("A vsync", 32'(vsync_a), 32'(ea.vs));
            chk("A display_on", 32'(de_a), 32'(ea.de));
            chk("A hpos", 32'(hpos_a), 32'(ea.h));
            chk("A vpos", 32'(vpos_a), 32'(ea.v));
            chk("A frame_start", 32'(fs_a), 32'(ea.fs));
            chk("A rgb", 32'(rgb_a), 32'(ea.rgb));
            if ((n_a % A_D) == 0 && n_a >= A_D) begin
                if (fm_a == 1 && ea.v == 0) begin
                    if (ea.h == 0) chk("A bar white", 32'(rgb_a), 32'hFFF);
                    if (ea.h == A_HD / 8) chk("A bar yellow", 32'(rgb_a), 32'h0FF);
                    if (ea.h == 7 * A_HD / 8) chk("A bar black first", 32'(rgb_a), 32'h000);
                    if (ea.h == A_HD - 1) chk("A bar black last", 32'(rgb_a), 32'h000);
                    if (ea.h == A_HD) begin
                        chk("A blank rgb", 32'(rgb_a), 32'h000);
                        chk("A blank de", 32'(de_a), 32'h0);
                    end
                end
                if (fm_a == 2 && ea.v == 0 && ea.h == 32) chk("A checker (32,0)", 32'(rgb_a), 32'hFFF);
                if (fm_a == 2 && ea.v == 0 && ea.h == 0) chk("A checker (0,0)", 32'(rgb_a), 32'h000);
                if (fm_a == 3 && ea.v == 12 && ea.h == 20) chk("A gradient (20,12)", 32'(rgb_a), 32'h435);
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (reset) begin
            n_b = 0;
        end else begin
            n_b++;
            eb = model(B_D, B_HD, B_HF, B_HS, B_HB, B_VD, B_VF, B_VS, B_VB, 0, B_CB, B_PW,
                       n_b, fm_b, 32'(mode_b));
            if (eb.fs) fm_b = 32'(mode_b);
            chk("B pix_ce", 32'(pix_ce_b), 32'(eb.ce));
            chk("B hsync", 32'(hsync_b), 32'(eb.hs));
            chk("B vsync", 32'(vsync_b), 32'(eb.vs));
            chk("B display_on", 32'(de_b), 32'(eb.de));
            chk("B hpos", 32'(hpos_b), 32'(eb.h));
            chk("B vpos", 32'(vpos_b), 32'(eb.v));
            chk("B frame_start", 32'(fs_b), 32'(eb.fs));
            chk("B rgb", 32'(rgb_b), 32'(eb.rgb));
            if (fm_b == 0 && eb.h == 8 && eb.v == 8) chk("B grid (8,8)", 32'(rgb_b), 32'h0000FF);
        end
    end

    initial begin
        mode_b = 2'd0;
        repeat (60) @(negedge clk);
        forever begin
            repeat ($urandom_range(50, 900)) @(negedge clk);
            mode_b = 2'($urandom_range(0, 3));
        end
    end

    initial begin
        reset  = 1'b1;
        mode_a = 2'd0;
        repeat (3) @(negedge clk);
        chk("A reset hsync", 32'(hsync_a), 32'h1);
        chk("A reset vsync", 32'(vsync_a), 32'h1);
        chk("A reset rgb", 32'(rgb_a), 32'h0);
        chk("A reset frame_start", 32'(fs_a), 32'h0);
        chk("B reset hsync", 32'(hsync_b), 32'h0);
        chk("B reset vsync", 32'(vsync_b), 32'h0);
        reset = 1'b0;

        // grid frame, switch to checker mid-frame; then bars, then gradient
        repeat (A_FRAME / 2) @(negedge clk);
        mode_a = 2'd2;
        repeat (A_FRAME) @(negedge clk);
        mode_a = 2'd1;
        repeat (A_FRAME) @(negedge clk);
        mode_a = 2'd3;
        repeat (A_FRAME) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            repeat ($urandom_range(100, 4000)) @(negedge clk);
            mode_a = 2'($urandom_range(0, 3));
        end

        // asynchronous reset mid-line, away from the clock edge
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("A async hpos", 32'(hpos_a), 32'h0);
        chk("A async vpos", 32'(vpos_a), 32'h0);
        chk("A async de", 32'(de_a), 32'h0);
        chk("A async rgb", 32'(rgb_a), 32'h0);
        chk("A async hsync", 32'(hsync_a), 32'h1);
        chk("A async vsync", 32'(vsync_a), 32'h1);
        chk("A async pix_ce", 32'(pix_ce_a), 32'h0);
        chk("B async pix_ce", 32'(pix_ce_b), 32'h1);
        chk("B async hsync", 32'(hsync_b), 32'h0);
        chk("B async rgb", 32'(rgb_b), 32'h0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (A_D) @(posedge clk);
        #1;
        chk("A restart frame_start", 32'(fs_a), 32'h1);
        chk("A restart hpos", 32'(hpos_a), 32'h0);
        chk("A restart vpos", 32'(vpos_a), 32'h0);

        repeat (A_FRAME + 200) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
